// File: rtl/mprj_wb_pkg.sv
// Shared definitions for the management-to-user Wishbone timeout bridge:
// the bridge state encoding and the default word returned for aborted reads.
package mprj_wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ABORT = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [31:0] DEFAULT_TIMEOUT_DATA = 32'hDEAD_BEEF;

    localparam int BUS_DW = 32;
    localparam int BUS_AW = 32;
    localparam int BUS_SW = 4;

endpackage

// File: rtl/mprj_wb_timer.sv
// Saturating cycle counter that watches how long the user side has held a
// request. expire is high once the count reaches TIMEOUT_CYCLES-1, which is
// the last cycle a request may stay open before the bridge gives up.
module mprj_wb_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Count REQ cycles; clear wins, and the count holds at LAST instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign expire = (count == LAST);

endmodule

// File: rtl/mprj_wb_timeout_bridge.sv
// Registered Wishbone bridge from the management core's exported user bus to
// the user project area. A user design that never acks is cut off after
// TIMEOUT_CYCLES and the CPU gets TIMEOUT_DATA instead of hanging.
// Optional sticky timeout flag: define MPRJ_WB_TIMEOUT_IRQ_EN.
module mprj_wb_timeout_bridge
    import mprj_wb_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = DEFAULT_TIMEOUT_DATA
) (
    input  logic              core_clk,
    input  logic              core_rstn,
    input  logic              mprj_wb_iena,
    input  logic              mprj_cyc_i,
    input  logic              mprj_stb_i,
    input  logic              mprj_we_i,
    input  logic [BUS_SW-1:0] mprj_sel_i,
    input  logic [BUS_AW-1:0] mprj_adr_i,
    input  logic [BUS_DW-1:0] mprj_dat_i,
    output logic              mprj_ack_o,
    output logic [BUS_DW-1:0] mprj_dat_o,
    output logic              u_cyc_o,
    output logic              u_stb_o,
    output logic              u_we_o,
    output logic [BUS_SW-1:0] u_sel_o,
    output logic [BUS_AW-1:0] u_adr_o,
    output logic [BUS_DW-1:0] u_dat_o,
    input  logic              u_ack_i,
    input  logic [BUS_DW-1:0] u_dat_i,
    input  logic              timeout_clr,
    output logic              timeout_irq
);

    state_t state;
    logic   abort_timeout;
    logic   expire;
    logic   timer_clear;
    logic   timer_enable;

    mprj_wb_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (core_clk),
        .rst_n (core_rstn),
        .clear (timer_clear),
        .enable(timer_enable),
        .expire(expire)
    );

    // Advance the timer while a request waits in REQ and reset it on the way out.
    always_comb begin
        timer_clear  = 1'b0;
        timer_enable = 1'b0;
        if (state == REQ) begin
            if (u_ack_i || !mprj_cyc_i || expire) begin
                timer_clear = 1'b1;
            end else begin
                timer_enable = 1'b1;
            end
        end
    end

    // Bridge FSM; every bus output is registered here so the user side sees clean timing.
    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            state         <= IDLE;
            abort_timeout <= 1'b0;
            mprj_ack_o    <= 1'b0;
            mprj_dat_o    <= '0;
            u_cyc_o       <= 1'b0;
            u_stb_o       <= 1'b0;
            u_we_o        <= 1'b0;
            u_sel_o       <= '0;
            u_adr_o       <= '0;
            u_dat_o       <= '0;
        end else begin
            mprj_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (mprj_cyc_i && mprj_stb_i) begin
                        if (mprj_wb_iena) begin
                            u_cyc_o <= 1'b1;
                            u_stb_o <= 1'b1;
                            u_we_o  <= mprj_we_i;
                            u_sel_o <= mprj_sel_i;
                            u_adr_o <= mprj_adr_i;
                            u_dat_o <= mprj_dat_i;
                            state   <= REQ;
                        end else begin
                            mprj_dat_o <= TIMEOUT_DATA;
                            mprj_ack_o <= 1'b1;
                            state      <= RESP;
                        end
                    end
                end
                REQ: begin
                    if (u_ack_i) begin
                        mprj_dat_o <= u_we_o ? '0 : u_dat_i;
                        mprj_ack_o <= 1'b1;
                        u_cyc_o    <= 1'b0;
                        u_stb_o    <= 1'b0;
                        state      <= RESP;
                    end else if (!mprj_cyc_i) begin
                        u_cyc_o       <= 1'b0;
                        u_stb_o       <= 1'b0;
                        abort_timeout <= 1'b0;
                        state         <= ABORT;
                    end else if (expire) begin
                        u_cyc_o       <= 1'b0;
                        u_stb_o       <= 1'b0;
                        abort_timeout <= 1'b1;
                        state         <= ABORT;
                    end
                end
                ABORT: begin
                    if (abort_timeout) begin
                        mprj_dat_o <= TIMEOUT_DATA;
                        mprj_ack_o <= 1'b1;
                        state      <= RESP;
                    end else begin
                        state <= IDLE;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MPRJ_WB_TIMEOUT_IRQ_EN
    // Sticky flag raised by a counter timeout; a new timeout beats a clear in the same cycle.
    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            timeout_irq <= 1'b0;
        end else if ((state == ABORT) && abort_timeout) begin
            timeout_irq <= 1'b1;
        end else if (timeout_clr) begin
            timeout_irq <= 1'b0;
        end
    end
`else
    logic unused_timeout_clr;

    assign unused_timeout_clr = timeout_clr;
    assign timeout_irq        = 1'b0;
`endif

endmodule
